clint_trap: RTL and testbench
=============================

CLINT_TRAP -- requirements
Module: clint_trap

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port inst_valid_i  input  1  instruction in execute stage is valid this cycle.
REQ-004 SHALL have port inst_pc_i  input  64  PC of the execute-stage instruction.
REQ-005 SHALL have port next_pc_i  input  64  PC of the next sequential or branch-resolved instruction.
REQ-006 SHALL have port ecall_i  input  1  execute-stage instruction is ECALL.
REQ-007 SHALL have port mret_i  input  1  execute-stage instruction is MRET.
REQ-008 SHALL have port cpu_csr_wen_i  input  1  pipeline CSR write in progress; the CSR file drops clint writes while this is high.
REQ-009 SHALL have ports csr_mtvec_i, csr_mepc_i, csr_mstatus_i  input  64 each  current CSR values.
REQ-010 SHALL have ports global_int_en_i, mtime_int_en_i, mtime_int_pend_i  input  1 each  mstatus.MIE, mie.MTIE, mip.MTIP.
REQ-011 SHALL have ports mepc_wen_o/mepc_wdata_o, mcause_wen_o/mcause_wdata_o, mstatus_wen_o/mstatus_wdata_o  output  1/64 each  CSR write ports.
REQ-012 SHALL have port redirect_valid_o  output  1  one-cycle PC redirect strobe.
REQ-013 SHALL have port redirect_pc_o  output  64  redirect target.
REQ-014 SHALL have port stall_o  output  1  freeze fetch/decode/execute.

Function
REQ-015 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, JUMP.
REQ-016 In IDLE with inst_valid_i=1, priority SHALL be: timer interrupt (global_int_en_i & mtime_int_en_i & mtime_int_pend_i) > ecall_i > mret_i.
REQ-017 Interrupt SHALL latch epc=next_pc_i and cause=64'h8000_0000_0000_0007; ecall SHALL latch epc=inst_pc_i and cause=64'd11; both go to W_MEPC.
REQ-018 MRET SHALL go to W_MRET.
REQ-019 W_MEPC, W_MCAUSE, W_MSTATUS and W_MRET SHALL each assert their write enable, and advance only in a cycle with cpu_csr_wen_i=0; while cpu_csr_wen_i=1 they SHALL hold state with wen deasserted.
REQ-020 W_MEPC SHALL write epc; W_MCAUSE SHALL write cause; W_MSTATUS SHALL write csr_mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11, other bits unchanged.
REQ-021 W_MRET SHALL write csr_mstatus_i with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11, other bits unchanged.
REQ-022 The trap target SHALL be {csr_mtvec_i[63:2],2'b00}; the MRET target SHALL be csr_mepc_i; both are sampled on entry to JUMP.
REQ-023 JUMP SHALL assert redirect_valid_o for exactly one cycle and then return to IDLE; redirect_pc_o SHALL be 0 whenever redirect_valid_o=0.
REQ-024 stall_o SHALL be 1 in every non-IDLE state and, combinationally, in the IDLE cycle in which an event is accepted.
REQ-025 Uncontended latency SHALL be: event at cycle T -> mepc write T+1, mcause T+2, mstatus T+3, redirect T+4; MRET at T -> mstatus T+1, redirect T+2.
REQ-026 Each cycle cpu_csr_wen_i=1 in a write state SHALL add exactly one cycle of latency.
REQ-027 Events arriving while not IDLE SHALL be ignored.
REQ-028 An event with inst_valid_i=0 SHALL be ignored.
REQ-029 All wdata SHALL be 0 when the matching wen is 0.

Reset
REQ-030 rst_n=0 at any clock edge, including mid-sequence, SHALL force IDLE, clear epc/cause/target latches, and drive every output to 0 in the next cycle.

Configuration
REQ-031 Macro CLINT_VECTORED_EN defined: when csr_mtvec_i[1:0]=2'b01 and the trap is an interrupt, target SHALL be base+64'd28 (4*cause code 7); ecall SHALL still use base.
REQ-032 Macro CLINT_VECTORED_EN undefined: target SHALL be base for every trap, and mtvec[1:0] SHALL be ignored.

Verification
REQ-033 ECALL at pc 0x8000_0100, mtvec=0x8000_0400, mstatus=0x1888 -> mepc=0x8000_0100 at T+1, mcause=11 at T+2, mstatus=0x1880 at T+3, redirect 0x8000_0400 at T+4.
REQ-034 Timer pending, MIE=1, MTIE=1, next_pc=0x8000_0204, mtvec=0x8000_0401 -> mcause=0x8000_0000_0000_0007; redirect 0x8000_041C with CLINT_VECTORED_EN, 0x8000_0400 without.
REQ-035 MRET with mstatus=0x1880, mepc=0x8000_0104 -> mstatus write 0x1888 at T+1, redirect 0x8000_0104 at T+2.
REQ-036 ECALL with cpu_csr_wen_i high for 2 cycles during W_MCAUSE -> mcause write delayed 2 cycles, redirect at T+6, stall_o high throughout.
REQ-037 rst_n low in W_MSTATUS -> next cycle all outputs 0, state IDLE, no redirect.
REQ-038 Interrupt and ecall in the same cycle -> interrupt taken with epc=next_pc_i; a second ECALL during the sequence is ignored.

Source files
------------

// File: rtl/clint_trap.sv
// Trap sequencer: commits timer interrupts, ECALL and MRET through mepc/mcause/mstatus
// CSR writes, then issues a one-cycle PC redirect. Optional macro: CLINT_VECTORED_EN.
module clint_trap (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_valid_i,
   input  logic [63:0] inst_pc_i,
   input  logic [63:0] next_pc_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        cpu_csr_wen_i,
   input  logic [63:0] csr_mtvec_i,
   input  logic [63:0] csr_mepc_i,
   input  logic [63:0] csr_mstatus_i,
   input  logic        global_int_en_i,
   input  logic        mtime_int_en_i,
   input  logic        mtime_int_pend_i,
   output logic        mepc_wen_o,
   output logic [63:0] mepc_wdata_o,
   output logic        mcause_wen_o,
   output logic [63:0] mcause_wdata_o,
   output logic        mstatus_wen_o,
   output logic [63:0] mstatus_wdata_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_pc_o,
   output logic        stall_o
);

   localparam logic [63:0] INT_CAUSE   = 64'h8000_0000_0000_0007;
   localparam logic [63:0] ECALL_CAUSE = 64'd11;
   localparam logic [63:0] INT_VEC_OFS = 64'd28;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      W_MRET,
      JUMP
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] epc, epc_nxt;
   logic [63:0] cause, cause_nxt;
   logic [63:0] target, target_nxt;
   logic        irq_take;
   logic [63:0] trap_base;
   logic [63:0] trap_target;

   // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
   function automatic logic [63:0] trap_mstatus(input logic [63:0] ms);
      logic [63:0] r;
      r        = ms;
      r[7]     = ms[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M.
   function automatic logic [63:0] mret_mstatus(input logic [63:0] ms);
      logic [63:0] r;
      r        = ms;
      r[3]     = ms[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   assign irq_take  = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
   assign trap_base = {csr_mtvec_i[63:2], 2'b00};

`ifdef CLINT_VECTORED_EN
   // Vectored mode only offsets interrupts; synchronous exceptions land on the base.
   assign trap_target = ((csr_mtvec_i[1:0] == 2'b01) && cause[63]) ? trap_base + INT_VEC_OFS
                                                                    : trap_base;
`else
   logic mtvec_mode_unused;
   assign mtvec_mode_unused = ^csr_mtvec_i[1:0];
   assign trap_target       = trap_base;
`endif

   always_comb begin
      state_nxt        = state;
      epc_nxt          = epc;
      cause_nxt        = cause;
      target_nxt       = target;
      mepc_wen_o       = 1'b0;
      mepc_wdata_o     = 64'd0;
      mcause_wen_o     = 1'b0;
      mcause_wdata_o   = 64'd0;
      mstatus_wen_o    = 1'b0;
      mstatus_wdata_o  = 64'd0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = 64'd0;
      stall_o          = 1'b0;

      case (state)
         IDLE: begin
            if (rst_n && inst_valid_i) begin
               if (irq_take) begin
                  epc_nxt   = next_pc_i;
                  cause_nxt = INT_CAUSE;
                  state_nxt = W_MEPC;
                  stall_o   = 1'b1;
               end else if (ecall_i) begin
                  epc_nxt   = inst_pc_i;
                  cause_nxt = ECALL_CAUSE;
                  state_nxt = W_MEPC;
                  stall_o   = 1'b1;
               end else if (mret_i) begin
                  state_nxt = W_MRET;
                  stall_o   = 1'b1;
               end
            end
         end

         // Each write state yields to a pipeline CSR write and retries next cycle.
         W_MEPC: begin
            stall_o = 1'b1;
            if (!cpu_csr_wen_i) begin
               mepc_wen_o   = 1'b1;
               mepc_wdata_o = epc;
               state_nxt    = W_MCAUSE;
            end
         end

         W_MCAUSE: begin
            stall_o = 1'b1;
            if (!cpu_csr_wen_i) begin
               mcause_wen_o   = 1'b1;
               mcause_wdata_o = cause;
               state_nxt      = W_MSTATUS;
            end
         end

         W_MSTATUS: begin
            stall_o = 1'b1;
            if (!cpu_csr_wen_i) begin
               mstatus_wen_o   = 1'b1;
               mstatus_wdata_o = trap_mstatus(csr_mstatus_i);
               target_nxt      = trap_target;
               state_nxt       = JUMP;
            end
         end

         W_MRET: begin
            stall_o = 1'b1;
            if (!cpu_csr_wen_i) begin
               mstatus_wen_o   = 1'b1;
               mstatus_wdata_o = mret_mstatus(csr_mstatus_i);
               target_nxt      = csr_mepc_i;
               state_nxt       = JUMP;
            end
         end

         JUMP: begin
            stall_o          = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target;
            state_nxt        = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         epc    <= 64'd0;
         cause  <= 64'd0;
         target <= 64'd0;
      end else begin
         state  <= state_nxt;
         epc    <= epc_nxt;
         cause  <= cause_nxt;
         target <= target_nxt;
      end
   end

endmodule

// File: tb/tb_clint_trap.sv
// Directed per-cycle vector table for clint_trap: each record holds the inputs of one
// cycle and the outputs expected in that same cycle.
module tb_clint_trap;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid_i;
   logic [63:0] inst_pc_i;
   logic [63:0] next_pc_i;
   logic        ecall_i;
   logic        mret_i;
   logic        cpu_csr_wen_i;
   logic [63:0] csr_mtvec_i;
   logic [63:0] csr_mepc_i;
   logic [63:0] csr_mstatus_i;
   logic        global_int_en_i;
   logic        mtime_int_en_i;
   logic        mtime_int_pend_i;
   logic        mepc_wen_o;
   logic [63:0] mepc_wdata_o;
   logic        mcause_wen_o;
   logic [63:0] mcause_wdata_o;
   logic        mstatus_wen_o;
   logic [63:0] mstatus_wdata_o;
   logic        redirect_valid_o;
   logic [63:0] redirect_pc_o;
   logic        stall_o;

   localparam logic [63:0] INT_CAUSE = 64'h8000_0000_0000_0007;
`ifdef CLINT_VECTORED_EN
   localparam logic [63:0] INT_TGT = 64'h0000_0000_8000_041C;
`else
   localparam logic [63:0] INT_TGT = 64'h0000_0000_8000_0400;
`endif

   clint_trap dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .inst_valid_i     (inst_valid_i),
      .inst_pc_i        (inst_pc_i),
      .next_pc_i        (next_pc_i),
      .ecall_i          (ecall_i),
      .mret_i           (mret_i),
      .cpu_csr_wen_i    (cpu_csr_wen_i),
      .csr_mtvec_i      (csr_mtvec_i),
      .csr_mepc_i       (csr_mepc_i),
      .csr_mstatus_i    (csr_mstatus_i),
      .global_int_en_i  (global_int_en_i),
      .mtime_int_en_i   (mtime_int_en_i),
      .mtime_int_pend_i (mtime_int_pend_i),
      .mepc_wen_o       (mepc_wen_o),
      .mepc_wdata_o     (mepc_wdata_o),
      .mcause_wen_o     (mcause_wen_o),
      .mcause_wdata_o   (mcause_wdata_o),
      .mstatus_wen_o    (mstatus_wen_o),
      .mstatus_wdata_o  (mstatus_wdata_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .stall_o          (stall_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        rst_n, vld, ecall, mret, cw;
      logic [2:0]  irq;     // {global_int_en, mtime_int_en, mtime_int_pend}
      logic [63:0] pc, npc, mtvec, mepc, mstatus;
      logic [2:0]  wen;     // {mepc, mcause, mstatus} expected write enables
      logic [63:0] wd;      // data expected on the one enabled write port
      logic        rv;
      logic [63:0] rpc;
      logic        stall;
   } vec_t;

   vec_t vq[$];
   logic [63:0] g_pc, g_npc, g_mtvec, g_mepc, g_mstatus;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic v(input logic rs, input logic vl, input logic ec, input logic mr,
                    input logic cw, input logic [2:0] irq, input logic [2:0] wen,
                    input logic [63:0] wd, input logic rv, input logic [63:0] rpc,
                    input logic st, input string tag);
      vec_t r;
      r.tag = tag;  r.rst_n = rs; r.vld = vl; r.ecall = ec; r.mret = mr; r.cw = cw;
      r.irq = irq;  r.pc = g_pc;  r.npc = g_npc; r.mtvec = g_mtvec;
      r.mepc = g_mepc; r.mstatus = g_mstatus;
      r.wen = wen;  r.wd = wd;    r.rv = rv; r.rpc = rpc; r.stall = st;
      vq.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; inst_valid_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; cpu_csr_wen_i = 1'b0;
      inst_pc_i = '0; next_pc_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
      global_int_en_i = 1'b0; mtime_int_en_i = 1'b0; mtime_int_pend_i = 1'b0;
      repeat (2) @(posedge clk);

      g_pc = 64'h8000_0100; g_npc = 64'h8000_0204; g_mtvec = 64'h8000_0400;
      g_mepc = 64'h8000_0104; g_mstatus = 64'h1888;

      v(0,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"reset");
      v(0,1,1,0,0,3'b111, 3'b000,64'h0,         0,64'h0,        0,"reset_evt");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"idle");
      // ECALL, uncontended
      v(1,1,1,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        1,"ecall_t0");
      v(1,0,0,0,0,3'b000, 3'b100,64'h8000_0100, 0,64'h0,        1,"ecall_mepc");
      v(1,0,0,0,0,3'b000, 3'b010,64'd11,        0,64'h0,        1,"ecall_mcause");
      v(1,0,0,0,0,3'b000, 3'b001,64'h1880,      0,64'h0,        1,"ecall_mstatus");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         1,64'h8000_0400,1,"ecall_jump");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"ecall_done");
      // MRET, uncontended
      g_mstatus = 64'h1880;
      v(1,1,0,1,0,3'b000, 3'b000,64'h0,         0,64'h0,        1,"mret_t0");
      v(1,0,0,0,0,3'b000, 3'b001,64'h1888,      0,64'h0,        1,"mret_mstatus");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         1,64'h8000_0104,1,"mret_jump");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"mret_done");
      // Timer interrupt with mtvec mode bits = 01
      g_mstatus = 64'h1888; g_mtvec = 64'h8000_0401;
      v(1,1,0,0,0,3'b111, 3'b000,64'h0,         0,64'h0,        1,"irq_t0");
      v(1,0,0,0,0,3'b000, 3'b100,64'h8000_0204, 0,64'h0,        1,"irq_mepc");
      v(1,0,0,0,0,3'b000, 3'b010,INT_CAUSE,     0,64'h0,        1,"irq_mcause");
      v(1,0,0,0,0,3'b000, 3'b001,64'h1880,      0,64'h0,        1,"irq_mstatus");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         1,INT_TGT,      1,"irq_jump");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"irq_done");
      // Interrupt beats a simultaneous ECALL; ECALLs during the sequence are ignored
      g_mtvec = 64'h8000_0400;
      v(1,1,1,0,0,3'b111, 3'b000,64'h0,         0,64'h0,        1,"prio_t0");
      v(1,1,1,0,0,3'b000, 3'b100,64'h8000_0204, 0,64'h0,        1,"prio_mepc");
      v(1,1,1,0,0,3'b000, 3'b010,INT_CAUSE,     0,64'h0,        1,"prio_mcause");
      v(1,1,1,0,0,3'b000, 3'b001,64'h1880,      0,64'h0,        1,"prio_mstatus");
      v(1,1,1,0,0,3'b000, 3'b000,64'h0,         1,64'h8000_0400,1,"prio_jump");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"prio_done");
      // ECALL with two contended cycles in W_MCAUSE; vectored mtvec still uses base
      g_mtvec = 64'h8000_0401;
      v(1,1,1,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        1,"cont_t0");
      v(1,0,0,0,0,3'b000, 3'b100,64'h8000_0100, 0,64'h0,        1,"cont_mepc");
      v(1,0,0,0,1,3'b000, 3'b000,64'h0,         0,64'h0,        1,"cont_hold1");
      v(1,0,0,0,1,3'b000, 3'b000,64'h0,         0,64'h0,        1,"cont_hold2");
      v(1,0,0,0,0,3'b000, 3'b010,64'd11,        0,64'h0,        1,"cont_mcause");
      v(1,0,0,0,0,3'b000, 3'b001,64'h1880,      0,64'h0,        1,"cont_mstatus");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         1,64'h8000_0400,1,"cont_jump");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"cont_done");
      // MRET with one contended cycle; mepc change during JUMP must not leak through
      g_mtvec = 64'h8000_0400; g_mstatus = 64'h1880;
      v(1,1,0,1,0,3'b000, 3'b000,64'h0,         0,64'h0,        1,"mretc_t0");
      v(1,0,0,0,1,3'b000, 3'b000,64'h0,         0,64'h0,        1,"mretc_hold");
      v(1,0,0,0,0,3'b000, 3'b001,64'h1888,      0,64'h0,        1,"mretc_mstatus");
      g_mepc = 64'h1234;
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         1,64'h8000_0104,1,"mretc_jump");
      g_mepc = 64'h8000_0104;
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"mretc_done");
      // Reset asserted while in W_MSTATUS
      g_mstatus = 64'h1888;
      v(1,1,1,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        1,"rstm_t0");
      v(1,0,0,0,0,3'b000, 3'b100,64'h8000_0100, 0,64'h0,        1,"rstm_mepc");
      v(1,0,0,0,0,3'b000, 3'b010,64'd11,        0,64'h0,        1,"rstm_mcause");
      v(0,0,0,0,0,3'b000, 3'b001,64'h1880,      0,64'h0,        1,"rstm_mstatus");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"rstm_after1");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"rstm_after2");
      // Events that must be ignored
      v(1,0,1,1,0,3'b111, 3'b000,64'h0,         0,64'h0,        0,"novld");
      v(1,1,0,0,0,3'b011, 3'b000,64'h0,         0,64'h0,        0,"irq_gie0");
      v(1,1,0,0,0,3'b101, 3'b000,64'h0,         0,64'h0,        0,"irq_mtie0");
      v(1,1,0,0,0,3'b110, 3'b000,64'h0,         0,64'h0,        0,"irq_nopend");
      v(1,0,0,0,0,3'b000, 3'b000,64'h0,         0,64'h0,        0,"final_idle");

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst_n            = vq[i].rst_n;
         inst_valid_i     = vq[i].vld;
         ecall_i          = vq[i].ecall;
         mret_i           = vq[i].mret;
         cpu_csr_wen_i    = vq[i].cw;
         global_int_en_i  = vq[i].irq[2];
         mtime_int_en_i   = vq[i].irq[1];
         mtime_int_pend_i = vq[i].irq[0];
         inst_pc_i        = vq[i].pc;
         next_pc_i        = vq[i].npc;
         csr_mtvec_i      = vq[i].mtvec;
         csr_mepc_i       = vq[i].mepc;
         csr_mstatus_i    = vq[i].mstatus;
         #1;
         chk($sformatf("%s mepc_wen", vq[i].tag),      mepc_wen_o,       vq[i].wen[2]);
         chk($sformatf("%s mepc_wdata", vq[i].tag),    mepc_wdata_o,     vq[i].wen[2] ? vq[i].wd : 64'h0);
         chk($sformatf("%s mcause_wen", vq[i].tag),    mcause_wen_o,     vq[i].wen[1]);
         chk($sformatf("%s mcause_wdata", vq[i].tag),  mcause_wdata_o,   vq[i].wen[1] ? vq[i].wd : 64'h0);
         chk($sformatf("%s mstatus_wen", vq[i].tag),   mstatus_wen_o,    vq[i].wen[0]);
         chk($sformatf("%s mstatus_wdata", vq[i].tag), mstatus_wdata_o,  vq[i].wen[0] ? vq[i].wd : 64'h0);
         chk($sformatf("%s redirect_valid", vq[i].tag), redirect_valid_o, vq[i].rv);
         chk($sformatf("%s redirect_pc", vq[i].tag),   redirect_pc_o,    vq[i].rpc);
         chk($sformatf("%s stall", vq[i].tag),         stall_o,          vq[i].stall);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
